// File: rtl/ripple_slice_sequencer.sv
// Multi-cycle W-bit adder wrapper around an external combinational N-bit ripple adder.
// Operands are accepted over a valid/ready handshake. The sequencer then drives one
// N-bit slice per clock into the adder and chains the carry between slices. The full
// sum is presented over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake; in_a, in_b, in_ci are the operands
//   add_a/add_b/add_ci slice driven to the adder (zero outside RUN)
//   add_sum/add_co    adder result, combinational from add_a/add_b/add_ci
//   out_valid/out_ready result handshake; out_sum, out_co, out_ovf are the result
module ripple_slice_sequencer #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_ci,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_ci,
  input  logic [N-1:0] add_sum,
  input  logic         add_co,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_co,
  output logic         out_ovf
);

  localparam int unsigned Slices = W / N;
  localparam int unsigned IdxW   = (Slices > 1) ? $clog2(Slices) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            co_q, co_d;

  // Operand registers viewed as slice arrays so the adder mux is a plain index.
  logic [N-1:0] a_sl [Slices];
  logic [N-1:0] b_sl [Slices];

  for (genvar g = 0; g < Slices; g++) begin : g_slice
    assign a_sl[g] = a_q[g*N +: N];
    assign b_sl[g] = b_q[g*N +: N];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    co_d      = co_q;
    add_a     = '0;
    add_b     = '0;
    add_ci    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_ci;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        add_a  = a_sl[idx_q];
        add_b  = b_sl[idx_q];
        add_ci = carry_q;
        for (int unsigned i = 0; i < Slices; i++) begin
          if (idx_q == IdxW'(i)) begin
            sum_d[i*N +: N] = add_sum;
          end
        end
        carry_d = add_co;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == IdxW'(Slices - 1)) begin
          co_d    = add_co;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
    end
  end

  assign out_sum = sum_q;
  assign out_co  = co_q;
  // Signed overflow: equal operand signs but a result sign that differs from them.
  assign out_ovf = (state_q == StDone) && (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_ripple_slice_sequencer.sv
module tb_ripple_slice_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;
  localparam int unsigned Slices = W / N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_ci;
  logic [N-1:0] add_sum;
  logic         add_co;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;

  ripple_slice_sequencer #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ci    (in_ci),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_ci   (add_ci),
    .add_sum  (add_sum),
    .add_co   (add_co),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_co   (out_co),
    .out_ovf  (out_ovf)
  );

  // Attached N-bit combinational ripple adder.
  logic [N:0] adder_res;
  assign adder_res = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_ci};
  assign add_sum   = adder_res[N-1:0];
  assign add_co    = adder_res[N];

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    int           hold;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Whole-word reference: plain integer addition and sign rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output logic [W-1:0] sum, output logic co, output logic ovf);
    longint unsigned full;
    full = longint'(a) + longint'(b) + longint'(ci);
    sum  = full[W-1:0];
    co   = full[W];
    ovf  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " in_ready"},  32'(in_ready),  32'd1);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_ovf"},   32'(out_ovf),   32'd0);
    chk({tag, " add_a"},     32'(add_a),     32'd0);
    chk({tag, " add_b"},     32'(add_b),     32'd0);
    chk({tag, " add_ci"},    32'(add_ci),    32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the output handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int hold, input logic [W-1:0] esum, input logic eco,
                        input logic eovf);
    int wait_cnt;
    longint unsigned m;
    longint unsigned cin;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("in_ready before accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_ci     = ci;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    for (int i = 0; i < Slices; i++) begin
      m   = (64'd1 << (i * N)) - 1;
      cin = ((longint'(a) & m) + (longint'(b) & m) + longint'(ci)) >> (i * N);
      chk("run add_a",     32'(add_a),     32'((a >> (i * N)) & 4'hF));
      chk("run add_b",     32'(add_b),     32'((b >> (i * N)) & 4'hF));
      chk("run add_ci",    32'(add_ci),    32'(cin));
      chk("run in_ready",  32'(in_ready),  32'd0);
      chk("run out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    chk("done out_valid", 32'(out_valid), 32'd1);
    chk("done out_sum",   32'(out_sum),   32'(esum));
    chk("done out_co",    32'(out_co),    32'(eco));
    chk("done out_ovf",   32'(out_ovf),   32'(eovf));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      @(negedge clk);
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold out_sum",   32'(out_sum),   32'(esum));
      chk("hold out_co",    32'(out_co),    32'(eco));
      chk("hold out_ovf",   32'(out_ovf),   32'(eovf));
      chk("hold in_ready",  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post in_ready",  32'(in_ready),  32'd1);
    chk("post out_valid", 32'(out_valid), 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    logic [W-1:0] ra, rb, rsum;
    logic         rci, rco, rovf;

    vecs[0] = '{a: 16'h1234, b: 16'h4321, ci: 1'b0, hold: 0, sum: 16'h5555, co: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, hold: 0, sum: 16'h0000, co: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0000, ci: 1'b1, hold: 0, sum: 16'h8000, co: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 16'h1234, b: 16'h4321, ci: 1'b0, hold: 5, sum: 16'h5555, co: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 16'h8000, b: 16'h8000, ci: 1'b0, hold: 1, sum: 16'h0000, co: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 16'h0F0F, b: 16'h00F1, ci: 1'b0, hold: 0, sum: 16'h1000, co: 1'b0, ovf: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'hAAAA;
    in_b      = 16'h5555;
    in_ci     = 1'b1;
    out_ready = 1'b1;
    #2;
    check_idle_outputs("reset");
    chk("reset out_sum", 32'(out_sum), 32'd0);
    chk("reset out_co",  32'(out_co),  32'd0);
    @(negedge clk);
    @(negedge clk);
    // Handshakes during reset must not have started anything.
    check_idle_outputs("in reset");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].hold, vecs[v].sum, vecs[v].co,
             vecs[v].ovf);
    end

    // Reset while idle after a nonzero result.
    rst_n = 1'b0;
    #1;
    check_idle_outputs("idle reset");
    chk("idle reset out_sum", 32'(out_sum), 32'd0);
    chk("idle reset out_co",  32'(out_co),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset after two RUN cycles discards the operation.
    in_valid = 1'b1;
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    in_ci    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("run reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("no valid after reset", 32'(out_valid), 32'd0);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 16'h1000, 1'b0, 1'b0);

    // Randomized operations against the whole-word model.
    for (int r = 0; r < 40; r++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rci = 1'($urandom);
      model(ra, rb, rci, rsum, rco, rovf);
      run_op(ra, rb, rci, int'($urandom_range(0, 2)), rsum, rco, rovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
